// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit path.
// Holds the baud constants used by uart_tx, the default inter-byte gap and
// accept timeout of the byte arbiter, the arbiter state encoding, and a small
// helper used to size its counter.
package uart_tx_arbiter_pkg;

  // Baud constants shared with uart_tx.
  localparam int CLK_FREQ_HZ = 32'd50_000_000;
  localparam int BAUD_RATE   = 32'd115_200;
  localparam int BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE;

  // Arbiter timing defaults, in clk cycles.
  localparam int DEF_GAP_CYCLES = 32'd2500;
  localparam int DEF_TIMEOUT    = 32'd4000;

  // Arbiter state encoding.
  localparam logic [3:0] ST_IDLE      = 4'h0;
  localparam logic [3:0] ST_START     = 4'h1;
  localparam logic [3:0] ST_WAIT_DONE = 4'h2;
  localparam logic [3:0] ST_GAP       = 4'h3;

  typedef enum logic [3:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_GAP       = ST_GAP
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin priority selector (purely combinational).
// Ports:
//   req   - request vector, one bit per requester
//   last  - index of the previous owner; the search starts just after it
//   index - first requesting index found, wrapping N_REQ-1 -> 0
//   valid - high when any request bit is set
module rr_select #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  // One spare bit so last + offset (at most 2*N_REQ-1) cannot overflow.
  localparam int CW = IDX_W + 1;

  logic [CW-1:0] sum_s;
  logic [CW-1:0] cand_s;
  logic          hit_s;

  // Walk offsets 1..N_REQ from the last owner and keep the first request seen.
  always_comb begin
    index  = '0;
    valid  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum_s = {1'b0, last} + CW'(k);
      if (sum_s >= CW'(N_REQ)) begin
        cand_s = sum_s - CW'(N_REQ);
      end else begin
        cand_s = sum_s;
      end
      hit_s = !valid && req[cand_s[IDX_W-1:0]];
      index = hit_s ? cand_s[IDX_W-1:0] : index;
      valid = valid | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Byte arbiter in front of a single uart_tx.
// Shares one UART among N_REQ byte requesters with round-robin ownership,
// optional ownership lock across bytes, an enforced idle gap after every byte
// and a timeout when the UART never accepts a start.
// Ports:
//   clk, rst           - clock; asynchronous active-high reset
//   req, lock, data    - per-requester request level, hold-ownership, byte
//   ack                - one-cycle pulse when a requester's byte is accepted
//   grant              - one-hot current owner, zero when idle
//   uart_data/start    - byte and start request to uart_tx
//   uart_ready         - uart_tx idle (1) / transmitting (0)
//   busy, err          - not idle; one-cycle timeout pulse
// All outputs are driven straight from flops.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         uart_data,
  output logic               uart_start,
  input  logic               uart_ready,
  output logic               busy,
  output logic               err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, TIMEOUT) + 1);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  // START counts down from TIMEOUT-1 so the timeout fires on the
  // TIMEOUT-th edge after entry.
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [7:0]       data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [N_REQ-1:0] ack_q,   ack_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             start_q, start_d;
  logic             busy_q,  busy_d;
  logic             err_q,   err_d;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             owner_keeps;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req   (req),
    .last  (last_q),
    .index (sel_idx),
    .valid (sel_valid)
  );

  // A locked owner keeps the UART only if it is still requesting.
  assign owner_keeps = lock[owner_q] & req[owner_q];

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid && uart_ready) begin
          owner_d = sel_idx;
          last_d  = sel_idx;
          data_d  = data[{sel_idx, 3'b000} +: 8];
          cnt_d   = TO_LOAD;
          state_d = S_START;
        end else begin
          cnt_d = '0;
        end
      end
      S_START: begin
        if (!uart_ready) begin
          ack_d[owner_q] = 1'b1;
          cnt_d          = '0;
          state_d        = S_WAIT_DONE;
        end else if (cnt_q == '0) begin
          // UART never took the byte: give up without acknowledging.
          err_d   = 1'b1;
          owner_d = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WAIT_DONE: begin
        if (uart_ready) begin
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          cnt_d = '0;
        end
      end
      S_GAP: begin
        // Leave when the decremented count would reach zero, so GAP lasts
        // exactly GAP_CYCLES cycles; the guard also keeps it from wrapping.
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (owner_keeps) begin
          data_d  = data[{owner_q, 3'b000} +: 8];
          cnt_d   = TO_LOAD;
          state_d = S_START;
        end else begin
          cnt_d   = '0;
          owner_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        owner_d = '0;
        state_d = S_IDLE;
      end
    endcase

    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
    grant_d = '0;
    if (busy_d) begin
      grant_d[owner_d] = 1'b1;
    end else begin
      grant_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      data_q  <= 8'h00;
      cnt_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign uart_data  = data_q;
  assign uart_start = start_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
